// File: rtl/bus_responder.sv
// bus_responder: memory-side responder for the multicycle RISC-V core's bus.
//
// Answers every addr/wdata/we request in the same cycle with no wait states.
// Read data is registered, so it appears one cycle after the address.
// Holds a word-addressed RAM and, optionally, a memory-mapped compare timer
// that drives the core's level-sensitive interrupt.
//
// Build option:
//   BUS_RESPONDER_TIMER_EN  defined   -> timer block built at TIMER_BASE
//                           undefined -> TIMER_BASE window unmapped, irq_o tied to 0
//
// Parameters:
//   MEM_WORDS   RAM depth in 32-bit words (power of two, >= 4)
//   TIMER_BASE  byte base address of the 16-byte timer register block
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   synchronous active-low reset
//   addr_i   byte address (bits [1:0] ignored)
//   wdata_i  write data
//   we_i     full-word write enable
//   rdata_o  registered read data
//   irq_o    registered interrupt request
//
// Timer registers (word offsets):
//   0 CTRL    [0] EN, [1] IRQ_EN, [2] AUTO_RELOAD
//   1 COUNT
//   2 COMPARE (resets to all ones)
//   3 STATUS  [0] MATCH, sticky, write 1 to clear

module bus_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [31:0] TIMER_BASE = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        we_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam int unsigned AddrW    = $clog2(MEM_WORDS);
  localparam logic [32:0] RamBytes = 33'(MEM_WORDS) << 2;

  // Address decode
  logic             ram_hit;
  logic             timer_hit;
  logic [AddrW-1:0] ram_idx;
  logic [1:0]       reg_idx;

  assign ram_hit   = ({1'b0, addr_i} < RamBytes);
  assign timer_hit = (addr_i[31:4] == TIMER_BASE[31:4]);
  assign ram_idx   = addr_i[AddrW+1:2];
  assign reg_idx   = addr_i[3:2];

  // RAM: not cleared by reset; an access presented during reset is dropped.
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (rst_ni && we_i && ram_hit) begin
      mem[ram_idx] <= wdata_i;
    end
  end

  logic [31:0] timer_rdata;

`ifdef BUS_RESPONDER_TIMER_EN
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        match_q, match_d;
  logic        irq_q, irq_d;
  logic        hit;
  logic        wr_ctrl, wr_count, wr_compare, wr_status;

  assign wr_ctrl    = we_i && timer_hit && (reg_idx == 2'd0);
  assign wr_count   = we_i && timer_hit && (reg_idx == 2'd1);
  assign wr_compare = we_i && timer_hit && (reg_idx == 2'd2);
  assign wr_status  = we_i && timer_hit && (reg_idx == 2'd3);

  // Match uses pre-edge COUNT/COMPARE and only counts while enabled.
  assign hit = ctrl_q[0] && (count_q == compare_q);

  always_comb begin
    ctrl_d    = wr_ctrl ? wdata_i[2:0] : ctrl_q;
    compare_d = wr_compare ? wdata_i : compare_q;

    if (wr_count) begin
      count_d = wdata_i;
    end else if (hit && ctrl_q[2]) begin
      count_d = 32'd0;
    end else if (ctrl_q[0]) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end

    // A new match beats a simultaneous write-1-to-clear.
    if (hit) begin
      match_d = 1'b1;
    end else if (wr_status && wdata_i[0]) begin
      match_d = 1'b0;
    end else begin
      match_d = match_q;
    end

    irq_d = match_d & ctrl_d[1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ctrl_q    <= 3'd0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      match_q   <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      match_q   <= match_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    timer_rdata = 32'd0;
    unique case (reg_idx)
      2'd0:    timer_rdata = {29'd0, ctrl_q};
      2'd1:    timer_rdata = count_q;
      2'd2:    timer_rdata = compare_q;
      2'd3:    timer_rdata = {31'd0, match_q};
      default: timer_rdata = 32'd0;
    endcase
  end

  assign irq_o = irq_q;
`else
  // Timer window behaves as unmapped space.
  assign timer_rdata = 32'd0;
  assign irq_o       = 1'b0;
`endif

  // Read path: selected location as it was before the edge (old value on
  // read-during-write).
  logic [31:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = 32'd0;
    if (ram_hit) begin
      rdata_d = mem[ram_idx];
    end else if (timer_hit) begin
      rdata_d = timer_rdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rdata_q <= 32'd0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_bus_responder.sv
module tb_bus_responder;

  localparam int unsigned MW  = 1024;
  localparam logic [31:0] TBA = 32'h8000_0000;
`ifdef BUS_RESPONDER_TIMER_EN
  localparam bit TimerEn = 1'b1;
`else
  localparam bit TimerEn = 1'b0;
`endif
  localparam logic [31:0] RamBytes = MW * 4;
  localparam logic [31:0] ACtrl    = TBA;
  localparam logic [31:0] ACount   = TBA + 32'd4;
  localparam logic [31:0] ACmp     = TBA + 32'd8;
  localparam logic [31:0] AStat    = TBA + 32'd12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        irq;

  always #5 clk = ~clk;

  bus_responder #(
    .MEM_WORDS (MW),
    .TIMER_BASE(TBA)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .addr_i (addr),
    .wdata_i(wdata),
    .we_i   (we),
    .rdata_o(rdata),
    .irq_o  (irq)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, evaluated once per clock edge.
  logic [31:0] mem_m [int unsigned];
  logic [31:0] m_ctrl = 0, m_count = 0, m_compare = 32'hFFFF_FFFF;
  logic        m_match = 0, m_irq = 0;
  logic [31:0] exp_rdata = 0;
  logic        exp_known = 1;

  task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] d,
                            input logic w);
    bit          is_ram, is_tmr, hit;
    int unsigned idx, rix;
    logic [31:0] n_count;
    is_ram = (a < RamBytes);
    is_tmr = TimerEn && ((a >> 4) == (TBA >> 4));
    idx    = a >> 2;
    rix    = (a >> 2) % 4;
    if (!r) begin
      m_ctrl = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_match = 0; m_irq = 0;
      exp_rdata = 0; exp_known = 1;
      return;
    end
    exp_known = 1;
    if (is_ram) begin
      if (mem_m.exists(idx)) exp_rdata = mem_m[idx];
      else exp_known = 0;
    end else if (is_tmr) begin
      case (rix)
        0: exp_rdata = m_ctrl;
        1: exp_rdata = m_count;
        2: exp_rdata = m_compare;
        default: exp_rdata = {31'd0, m_match};
      endcase
    end else begin
      exp_rdata = 0;
    end
    hit = (m_ctrl % 2 == 1) && (m_count == m_compare);
    if (is_tmr && w && rix == 1) n_count = d;
    else if (hit && m_ctrl[2]) n_count = 0;
    else if (m_ctrl % 2 == 1) n_count = m_count + 1;
    else n_count = m_count;
    if (hit) m_match = 1;
    else if (is_tmr && w && rix == 3 && d[0]) m_match = 0;
    m_count = n_count;
    if (is_tmr && w && rix == 0) m_ctrl = d & 32'd7;
    if (is_tmr && w && rix == 2) m_compare = d;
    m_irq = m_match && m_ctrl[1];
    if (is_ram && w) mem_m[idx] = d;
  endtask

  task automatic step(input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic w);
    rst_n = r; addr = a; wdata = d; we = w;
    model_step(r, a, d, w);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_cmp;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, ACmp, 32'h0, 1'b0);
      checks++;
      if (rdata !== 32'd0 || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: rdata=%h irq=%b required rdata=0 irq=0", rdata, irq);
      end
    end
    step(1'b1, ACmp, 32'h0, 1'b0);
    exp_cmp = TimerEn ? 32'hFFFF_FFFF : 32'h0;
    checks++;
    if (rdata !== exp_cmp || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_compare: rdata=%h irq=%b required %h irq=0", rdata, irq, exp_cmp);
    end
  endtask

  task automatic test_ram();
    for (int i = 0; i < 16; i++) step(1'b1, i * 4, $urandom, 1'b1);
    step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1);
    step(1'b1, 32'h10, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ram_read: got %h required deadbeef", rdata);
    end
    step(1'b1, 32'h14, 32'h1234, 1'b1);
    checks++;
    if (rdata !== exp_rdata) begin
      errors++;
      $display("FAIL ram_rdw_old: got %h required %h", rdata, exp_rdata);
    end
    step(1'b1, 32'h17, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h1234) begin
      errors++;
      $display("FAIL ram_rdw_new: got %h required 00001234", rdata);
    end
  endtask

  task automatic test_unmapped();
    step(1'b1, 32'h4000_0000, 32'h5555_5555, 1'b1);
    step(1'b1, 32'h4000_0000, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL unmapped_read: got %h required 0", rdata);
    end
    step(1'b1, RamBytes, 32'h0, 1'b0);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL ram_end_read: got %h required 0", rdata);
    end
  endtask

  task automatic test_match_irq();
    step(1'b1, ACtrl, 32'd0, 1'b1);
    step(1'b1, ACmp, 32'd5, 1'b1);
    step(1'b1, ACount, 32'd0, 1'b1);
    step(1'b1, ACtrl, 32'd3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, (i % 2 == 0) ? ACount : AStat, 32'd0, 1'b0);
      checks++;
      if (rdata !== exp_rdata || irq !== m_irq) begin
        errors++;
        $display("FAIL match_seq[%0d]: rdata=%h irq=%b required %h irq=%b",
                 i, rdata, irq, exp_rdata, m_irq);
      end
    end
    step(1'b1, AStat, 32'd1, 1'b1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL status_clear_irq: irq=%b required 0", irq);
    end
    step(1'b1, AStat, 32'd0, 1'b0);
    checks++;
    if (rdata !== 32'd0 || irq !== m_irq) begin
      errors++;
      $display("FAIL status_cleared: rdata=%h irq=%b required 0 irq=%b", rdata, irq, m_irq);
    end
  endtask

  task automatic test_reload_wrap();
    step(1'b1, ACtrl, 32'd0, 1'b1);
    step(1'b1, ACount, 32'd0, 1'b1);
    step(1'b1, ACmp, 32'd3, 1'b1);
    step(1'b1, ACtrl, 32'd7, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, ACount, 32'd0, 1'b0);
      checks++;
      if (rdata !== (TimerEn ? (i % 4) : 0) || irq !== m_irq) begin
        errors++;
        $display("FAIL reload_seq[%0d]: rdata=%h irq=%b required %h irq=%b",
                 i, rdata, irq, TimerEn ? (i % 4) : 0, m_irq);
      end
    end
    step(1'b1, ACtrl, 32'd0, 1'b1);
    step(1'b1, AStat, 32'd1, 1'b1);
    step(1'b1, ACmp, 32'd5, 1'b1);
    step(1'b1, ACount, 32'hFFFF_FFFE, 1'b1);
    step(1'b1, ACtrl, 32'd1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, ACount, 32'd0, 1'b0);
      checks++;
      if (rdata !== exp_rdata) begin
        errors++;
        $display("FAIL wrap_seq[%0d]: got %h required %h", i, rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_priorities();
    step(1'b1, ACtrl, 32'd1, 1'b1);
    step(1'b1, ACount, 32'h100, 1'b1);
    step(1'b1, ACount, 32'd0, 1'b0);
    checks++;
    if (rdata !== (TimerEn ? 32'h100 : 32'h0)) begin
      errors++;
      $display("FAIL count_write_prio: got %h required %h", rdata, TimerEn ? 32'h100 : 0);
    end
    step(1'b1, ACtrl, 32'd0, 1'b1);
    step(1'b1, AStat, 32'd1, 1'b1);
    step(1'b1, ACount, 32'd10, 1'b1);
    step(1'b1, ACmp, 32'd12, 1'b1);
    step(1'b1, ACtrl, 32'd3, 1'b1);
    step(1'b1, ACount, 32'd0, 1'b0);
    step(1'b1, ACount, 32'd0, 1'b0);
    // COUNT == COMPARE in this cycle; the clear must lose.
    step(1'b1, AStat, 32'd1, 1'b1);
    step(1'b1, AStat, 32'd0, 1'b0);
    checks++;
    if (rdata !== {31'd0, TimerEn} || irq !== TimerEn) begin
      errors++;
      $display("FAIL clear_vs_match: rdata=%h irq=%b required %h irq=%b",
               rdata, irq, {31'd0, TimerEn}, TimerEn);
    end
    step(1'b0, ACount, 32'h77, 1'b1);
    checks++;
    if (rdata !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: rdata=%h irq=%b required 0 irq=0", rdata, irq);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, TBA + i * 4, 32'd0, 1'b0);
      checks++;
      if (rdata !== exp_rdata || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_regs[%0d]: rdata=%h irq=%b required %h irq=0",
                 i, rdata, irq, exp_rdata);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    logic        w, r;
    int unsigned kind;
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      w    = $urandom_range(0, 2) == 0;
      d    = $urandom;
      r    = $urandom_range(0, 49) != 0;
      if (kind < 4) begin
        a = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
      end else if (kind < 8) begin
        a = TBA + $urandom_range(0, 15);
        if ((a >> 2) % 4 != 3) d = $urandom_range(0, 20);
        if ((a >> 2) % 4 == 0) d = $urandom_range(0, 7);
      end else if (kind == 8) begin
        a = 32'h4000_0000 | ($urandom % 32'h1000_0000);
      end else begin
        a = RamBytes + $urandom_range(0, 63);
      end
      step(r, a, d, w);
      checks++;
      if ((exp_known && rdata !== exp_rdata) || irq !== m_irq) begin
        errors++;
        $display("FAIL random[%0d]: addr=%h rdata=%h irq=%b required %h irq=%b",
                 i, a, rdata, irq, exp_rdata, m_irq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_unmapped();
    test_match_irq();
    test_reload_wrap();
    test_priorities();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
